cond_unit: RTL and testbench

- Condition-check and write-gating block for the multicycle ARM datapath.
- Consumes the 4-bit ALU flag vector {N,Z,C,V} and holds the architectural flags register.
- Evaluates the 4-bit instruction condition field and gates PC, register-file and memory writes.
- Sits between the main control FSM/decoder and the datapath write enables; also keeps a saturating count of condition-failed instructions.

---
 rtl/cond_unit.sv | 61 ++++++
 tb/tb_cond_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// cond_unit: ARM condition check, flags register and write gating with saturating skip counter.
// Optional COND_FLAG_BYPASS_EN: evaluate conditions against next-state flags instead of registered flags.
module cond_unit #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           cond,
    input  logic [3:0]           alu_flags,
    input  logic [1:0]           flag_w,
    input  logic                 cond_latch,
    input  logic                 pcs,
    input  logic                 reg_w,
    input  logic                 mem_w,
    input  logic                 no_write,
    input  logic                 skip_clr,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 mem_write,
    output logic [3:0]           flags,
    output logic                 cond_ex,
    output logic [CNT_WIDTH-1:0] skip_count
);
    logic       nz_en, cv_en, pass;
    logic [3:0] f_eval;
    logic [7:0] base;

    assign nz_en = flag_w[1] & cond_ex;
    assign cv_en = flag_w[0] & cond_ex;

`ifdef COND_FLAG_BYPASS_EN
    assign f_eval = {nz_en ? alu_flags[3:2] : flags[3:2], cv_en ? alu_flags[1:0] : flags[1:0]};
`else
    assign f_eval = flags;
`endif

    // Odd codes are the negation of the preceding even code; 14/15 always pass.
    always_comb begin
        base = {1'b1, ~f_eval[2] & (f_eval[3] == f_eval[0]), f_eval[3] == f_eval[0],
                f_eval[1] & ~f_eval[2], f_eval[0], f_eval[3], f_eval[1], f_eval[2]};
        pass = (cond[3:1] == 3'd7) | (base[cond[3:1]] ^ cond[0]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags      <= '0;
            cond_ex    <= 1'b0;
            skip_count <= '0;
        end else begin
            if (nz_en) flags[3:2] <= alu_flags[3:2];
            if (cv_en) flags[1:0] <= alu_flags[1:0];
            if (cond_latch) cond_ex <= pass;
            if (skip_clr) skip_count <= '0;
            else if (cond_latch && !pass && skip_count != '1) skip_count <= skip_count + CNT_WIDTH'(1);
        end
    end

    assign pc_write  = pcs & cond_ex;
    assign reg_write = reg_w & cond_ex & ~no_write;
    assign mem_write = mem_w & cond_ex;
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed self-checking bench for cond_unit (CNT_WIDTH=2 to reach saturation).
module tb_cond_unit;
    logic       clk = 1'b0, reset = 1'b0;
    logic [3:0] cond = '0, alu_flags = '0;
    logic [1:0] flag_w = '0;
    logic       cond_latch = 1'b0, pcs = 1'b0, reg_w = 1'b0, mem_w = 1'b0, no_write = 1'b0, skip_clr = 1'b0;
    logic       pc_write, reg_write, mem_write, cond_ex;
    logic [3:0] flags;
    logic [1:0] skip_count;
    int         checks = 0, failures = 0;

    cond_unit #(.CNT_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .cond(cond), .alu_flags(alu_flags), .flag_w(flag_w),
        .cond_latch(cond_latch), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
        .skip_clr(skip_clr), .pc_write(pc_write), .reg_write(reg_write), .mem_write(mem_write),
        .flags(flags), .cond_ex(cond_ex), .skip_count(skip_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic latch(input logic [3:0] c);
        cond = c;
        cond_latch = 1'b1;
        step();
        cond_latch = 1'b0;
    endtask

    initial begin
        reg_w = 1'b1;
        #2;
        chk("rst_flags", 32'(flags), 0);
        chk("rst_cond_ex", 32'(cond_ex), 0);
        chk("rst_skip", 32'(skip_count), 0);
        chk("rst_reg_write", 32'(reg_write), 0);
        #10 reset = 1'b1;
        step();
        chk("prelatch_reg_write", 32'(reg_write), 0);
        latch(4'hE);
        chk("al_cond_ex", 32'(cond_ex), 1);
        chk("al_reg_write", 32'(reg_write), 1);
        no_write = 1'b1;
        #1 chk("no_write", 32'(reg_write), 0);
        no_write = 1'b0;
        reg_w = 1'b0;
        // full flag write, then EQ pass / NE fail
        alu_flags = 4'b0100; flag_w = 2'b11;
        step();
        flag_w = 2'b00;
        chk("flag_upd", 32'(flags), 32'b0100);
        latch(4'h0);
        chk("eq_pass", 32'(cond_ex), 1);
        latch(4'h1);
        mem_w = 1'b1;
        #1;
        chk("ne_fail", 32'(cond_ex), 0);
        chk("ne_mem_write", 32'(mem_write), 0);
        chk("ne_skip", 32'(skip_count), 1);
        mem_w = 1'b0;
        // partial group write
        latch(4'hE);
        alu_flags = 4'b0000; flag_w = 2'b11;
        step();
        chk("flags_zero", 32'(flags), 0);
        alu_flags = 4'b1111; flag_w = 2'b10;
        step();
        flag_w = 2'b00;
        chk("nz_only", 32'(flags), 32'b1100);
        latch(4'hA);
        chk("ge_fail", 32'(cond_ex), 0);
        chk("ge_skip", 32'(skip_count), 2);
        latch(4'hB);
        chk("lt_pass", 32'(cond_ex), 1);
        chk("lt_skip", 32'(skip_count), 2);
        // gated flag write with cond_ex=0
        latch(4'h1);
        chk("ne_fail2", 32'(cond_ex), 0);
        flag_w = 2'b11; alu_flags = 4'b1111;
        step();
        flag_w = 2'b00;
        chk("gated_flags", 32'(flags), 32'b1100);
        pcs = 1'b1;
        #1 chk("gated_pc_write", 32'(pc_write), 0);
        pcs = 1'b0;
        // counter saturation and clear priority
        skip_clr = 1'b1;
        step();
        skip_clr = 1'b0;
        chk("skip_clr", 32'(skip_count), 0);
        for (int i = 0; i < 4; i++) begin
            latch(4'h1);
            chk($sformatf("sat_%0d", i), 32'(skip_count), (i < 3) ? i + 1 : 3);
        end
        skip_clr = 1'b1;
        latch(4'h1);
        skip_clr = 1'b0;
        chk("clr_over_inc", 32'(skip_count), 0);
        // async reset mid-cycle
        latch(4'hE);
        chk("pre_rst_cond_ex", 32'(cond_ex), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_flags", 32'(flags), 0);
        chk("async_cond_ex", 32'(cond_ex), 0);
        #1 reset = 1'b1;
        reg_w = 1'b1;
        step();
        chk("post_rst_reg_write", 32'(reg_write), 0);
        reg_w = 1'b0;
        // same-cycle flag write and EQ evaluation
        latch(4'hE);
        alu_flags = 4'b0100; flag_w = 2'b10;
        latch(4'h0);
        flag_w = 2'b00;
        chk("byp_flags", 32'(flags), 32'b0100);
`ifdef COND_FLAG_BYPASS_EN
        chk("byp_cond_ex", 32'(cond_ex), 1);
        chk("byp_skip", 32'(skip_count), 0);
`else
        chk("byp_cond_ex", 32'(cond_ex), 0);
        chk("byp_skip", 32'(skip_count), 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
